// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/COMMIT with stretched execute for mul/div and INPUT.
// Optional mul/div timeout fault is built when MULDIV_TIMEOUT_EN is defined.
module instr_sequencer #(
  parameter int MULDIV_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       jump_taken,
  input  logic       muldiv_done,
  input  logic       input_valid,
  output logic       input_ack,
  output logic       ir_load,
  output logic       alu_start,
  output logic       reg_we_gate,
  output logic       data_we_gate,
  output logic       pc_en,
  output logic       pc_load,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_WAIT_ALU = 3'd4,
    S_WAIT_IN  = 3'd5,
    S_COMMIT   = 3'd6,
    S_HALT     = 3'd7
  } state_t;

  state_t state_q, state_d;
  logic   timeout_hit;
  logic   op_regw, op_memw, op_jump, op_muldiv, op_input, op_halt;

  assign state = state_q;

  // Opcode classes; opcode 7 (push/pop) raises both write gates.
  always_comb begin
    op_regw   = 1'b0;
    op_memw   = 1'b0;
    op_jump   = 1'b0;
    op_muldiv = 1'b0;
    op_input  = 1'b0;
    op_halt   = 1'b0;
    case (opcode)
      4'h0, 4'h1, 4'h5, 4'h8, 4'h9, 4'hA: op_regw = 1'b1;
      4'h2, 4'h3: begin
        op_regw   = 1'b1;
        op_muldiv = 1'b1;
      end
      4'h6: op_jump = 1'b1;
      4'h7: begin
        op_regw = 1'b1;
        op_memw = 1'b1;
      end
      4'hB: op_memw = 1'b1;
      4'hD: begin
        op_regw  = 1'b1;
        op_input = 1'b1;
      end
      4'hF: op_halt = 1'b1;
      default: ;
    endcase
  end

`ifdef MULDIV_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(MULDIV_TIMEOUT - 1);
  logic [7:0] alu_cnt;
  logic       fault_q;

  // muldiv_done in the limit cycle takes priority over the timeout.
  assign timeout_hit = (state_q == S_WAIT_ALU) && !muldiv_done && (alu_cnt == TIMEOUT_LAST);
  assign fault       = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_cnt <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state_q == S_EXEC) begin
        alu_cnt <= '0;
      end else if (state_q == S_WAIT_ALU) begin
        alu_cnt <= alu_cnt + 8'd1;
      end
      if (timeout_hit) begin
        fault_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  // Always 0; the parameter only matters in the timeout build.
  assign fault       = (MULDIV_TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_load      = 1'b0;
    alu_start    = 1'b0;
    reg_we_gate  = 1'b0;
    data_we_gate = 1'b0;
    pc_en        = 1'b0;
    pc_load      = 1'b0;
    input_ack    = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        ir_load = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = op_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        alu_start = op_muldiv;
        if (op_muldiv)     state_d = S_WAIT_ALU;
        else if (op_input) state_d = S_WAIT_IN;
        else               state_d = S_COMMIT;
      end
      S_WAIT_ALU: begin
        if (muldiv_done)      state_d = S_COMMIT;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_WAIT_IN: begin
        input_ack = input_valid;
        if (input_valid) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        pc_en        = 1'b1;
        pc_load      = op_jump & jump_taken;
        reg_we_gate  = op_regw;
        data_we_gate = op_memw;
        state_d      = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
        if (!run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios then randomized instruction stream,
// each cycle compared against an instruction-level model of the strobe trace.
module tb_instr_sequencer;

  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [3:0] opcode;
  logic       jump_taken;
  logic       muldiv_done;
  logic       input_valid;
  logic       input_ack, ir_load, alu_start, reg_we_gate, data_we_gate;
  logic       pc_en, pc_load, halted, fault;
  logic [2:0] state;

  int   vectors = 0;
  int   miscompares = 0;
  logic exp_fault = 1'b0;

  instr_sequencer #(.MULDIV_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .jump_taken(jump_taken),
    .muldiv_done(muldiv_done), .input_valid(input_valid), .input_ack(input_ack),
    .ir_load(ir_load), .alu_start(alu_start), .reg_we_gate(reg_we_gate),
    .data_we_gate(data_we_gate), .pc_en(pc_en), .pc_load(pc_load),
    .halted(halted), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // Expected packed vector: {ir_load, alu_start, reg_we, data_we, pc_en, pc_load, input_ack, halted, fault, state}
  function automatic logic [11:0] ev(input logic il, input logic as_, input logic rw, input logic dw,
                                     input logic pe, input logic pl, input logic ia, input logic h,
                                     input logic [2:0] st);
    return {il, as_, rw, dw, pe, pl, ia, h, exp_fault, st};
  endfunction

  // Instruction classes straight from the opcode table.
  task automatic classify(input logic [3:0] op, output logic rw, output logic dw, output logic jmp,
                          output logic md, output logic inp, output logic hlt);
    rw  = (op inside {4'h0, 4'h1, 4'h5, 4'h8, 4'h9, 4'hA, 4'h2, 4'h3, 4'hD, 4'h7});
    dw  = (op inside {4'h7, 4'hB});
    jmp = (op == 4'h6);
    md  = (op inside {4'h2, 4'h3});
    inp = (op == 4'hD);
    hlt = (op == 4'hF);
  endtask

  // Inputs are driven just after the falling edge; outputs checked 1 time unit later.
  task automatic tick(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    #1;
    obs = {ir_load, alu_start, reg_we_gate, data_we_gate, pc_en, pc_load, input_ack, halted, fault, state};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    @(negedge clk);
  endtask

  task automatic noise();
    muldiv_done = 1'($urandom_range(0, 1));
    input_valid = 1'($urandom_range(0, 1));
    jump_taken  = 1'($urandom_range(0, 1));
    run         = 1'($urandom_range(0, 1));
  endtask

  // Runs one instruction starting in FETCH. lat = WAIT cycles including the completing one.
  // For opcode F it stops once the DECODE cycle is checked (next state HALT).
  task automatic do_instr(input logic [3:0] op, input logic jt, input int lat, input logic run_after);
    logic rw, dw, jmp, md, inp, hlt;
    classify(op, rw, dw, jmp, md, inp, hlt);
    opcode = op;
    noise();
    tick("fetch", ev(1, 0, 0, 0, 0, 0, 0, 0, 3'd1));
    noise();
    tick("decode", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd2));
    if (hlt) return;
    noise();
    tick("exec", ev(0, md, 0, 0, 0, 0, 0, 0, 3'd3));
    if (md) begin
      for (int k = 1; k <= lat; k++) begin
        noise();
        muldiv_done = (k == lat);
        tick("wait_alu", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd4));
      end
    end
    if (inp) begin
      for (int k = 1; k <= lat; k++) begin
        noise();
        input_valid = (k == lat);
        tick("wait_in", ev(0, 0, 0, 0, 0, 0, (k == lat), 0, 3'd5));
      end
    end
    noise();
    run        = run_after;
    jump_taken = jt;
    tick("commit", ev(0, 0, rw, dw, 1, jmp & jt, 0, 0, 3'd6));
  endtask

  // From HALT: stay a few cycles, drop run, then resume into FETCH.
  task automatic leave_halt(input int stay);
    for (int k = 0; k < stay; k++) begin
      noise();
      run = 1'b1;
      tick("halt", ev(0, 0, 0, 0, 0, 0, 0, 1, 3'd7));
    end
    noise();
    run = 1'b0;
    tick("halt_exit", ev(0, 0, 0, 0, 0, 0, 0, 1, 3'd7));
    noise();
    run = 1'b1;
    tick("idle_after_halt", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
  endtask

  // From IDLE after a COMMIT with run=0: linger, then resume into FETCH.
  task automatic resume_from_idle();
    noise();
    run = 1'b0;
    tick("idle_hold", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
    noise();
    run = 1'b1;
    tick("idle_go", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
  endtask

  initial begin
    logic [3:0] op;
    logic       ra;
    rst_n = 1'b0; run = 1'b0; opcode = 4'h0;
    jump_taken = 1'b0; muldiv_done = 1'b0; input_valid = 1'b0;
    @(negedge clk);
    tick("reset", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
    rst_n = 1'b1;
    run   = 1'b1;
    tick("idle_run", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));

    // Directed scenarios
    do_instr(4'h0, 1'b0, 1, 1'b1);
    do_instr(4'h2, 1'b0, 3, 1'b1);
    do_instr(4'h6, 1'b1, 1, 1'b1);
    do_instr(4'h6, 1'b0, 1, 1'b1);
    do_instr(4'hD, 1'b0, 6, 1'b1);
    do_instr(4'h7, 1'b0, 1, 1'b1);
    do_instr(4'hB, 1'b0, 1, 1'b0);
    resume_from_idle();
    do_instr(4'hF, 1'b0, 1, 1'b1);
    leave_halt(3);

    // Asynchronous reset while in WAIT_ALU
    opcode = 4'h2; run = 1'b1; muldiv_done = 1'b0; input_valid = 1'b0;
    tick("rst_fetch", ev(1, 0, 0, 0, 0, 0, 0, 0, 3'd1));
    tick("rst_decode", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd2));
    tick("rst_exec", ev(0, 1, 0, 0, 0, 0, 0, 0, 3'd3));
    tick("rst_wait", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd4));
    rst_n = 1'b0;
    tick("reset_mid", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
    rst_n = 1'b1;
    tick("idle_post_rst", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) != 0);
      do_instr(op, 1'($urandom_range(0, 1)), $urandom_range(1, 6), ra);
      if (op == 4'hF) leave_halt($urandom_range(0, 3));
      else if (!ra) resume_from_idle();
    end

`ifdef MULDIV_TIMEOUT_EN
    // muldiv_done in the limit cycle still commits
    do_instr(4'h2, 1'b0, TIMEOUT, 1'b1);
    // No muldiv_done: timeout into HALT with sticky fault
    opcode = 4'h3; run = 1'b1; muldiv_done = 1'b0; input_valid = 1'b0;
    tick("to_fetch", ev(1, 0, 0, 0, 0, 0, 0, 0, 3'd1));
    tick("to_decode", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd2));
    tick("to_exec", ev(0, 1, 0, 0, 0, 0, 0, 0, 3'd3));
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick("to_wait", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd4));
    end
    exp_fault = 1'b1;
    leave_halt(2);
    do_instr(4'h1, 1'b0, 1, 1'b1);
    rst_n = 1'b0;
    exp_fault = 1'b0;
    tick("fault_reset", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
    rst_n = 1'b1;
    run = 1'b0;
    tick("fault_idle", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
